// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin and register-bank signal bundle for spi_slave
interface spi_slave_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cs;
    logic                  sck;
    logic                  sdi;
    logic                  sdo;
    logic                  sdo_oe;
    logic                  wr_en;
    logic [ADDR_WIDTH-2:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_req;
    logic [ADDR_WIDTH-2:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  frame_err;

    // The responder: consumes pins and read data, produces requests.
    modport slave (
        input  cs, sck, sdi, rd_data,
        output sdo, sdo_oe, wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err
    );

    // The environment: initiator pins plus the register bank.
    modport master (
        output cs, sck, sdi, rd_data,
        input  sdo, sdo_oe, wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI responder producing register-file read/write requests
module spi_slave #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int SCK_RISING_SHIFT = 1,
    parameter int RD_LATENCY       = 1
) (
    input  logic clk,
    input  logic rst,
    spi_slave_if.slave bus
);
    localparam int FRAME = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW    = $clog2(FRAME + 2) + 1;
    // Shift storage must hold the whole address at its last fall and the data word at frame end.
    localparam int SW    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH + 1;

    localparam logic [CW-1:0] CNT_ADDR   = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] CNT_FRAME  = CW'(FRAME);
    localparam logic [CW-1:0] CNT_SHIFT0 = CW'(ADDR_WIDTH + 2);
    localparam logic [2:0]    LAT        = 3'(RD_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_t;

    state_t state;

    logic [2:0]            cs_q;
    logic [2:0]            sck_q;
    logic [1:0]            sdi_q;
    logic                  sck_in;
    logic                  cs_fall, cs_rise, sck_fall, sck_rise;

    logic [CW-1:0]         fall_cnt, rise_cnt;
    logic [CW-1:0]         fall_inc, rise_inc;
    logic [SW-2:0]         shreg;
    logic [SW-1:0]         shreg_nxt;
    logic [ADDR_WIDTH-2:0] addr_q;
    logic                  is_read;
    logic                  overrun;
    logic                  loaded;
    logic [2:0]            lat_cnt;

    logic [DATA_WIDTH-1:0] sdo_sh;
    logic                  sdo_oe_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-2:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  rd_req_q;
    logic [ADDR_WIDTH-2:0] rd_addr_q;
    logic                  frame_err_q;

    // Fold the clock polarity option in before synchronizing so the core only sees "shift on rise".
    assign sck_in = (SCK_RISING_SHIFT != 0) ? bus.sck : ~bus.sck;

    assign cs_fall  =  cs_q[2]  & ~cs_q[1];
    assign cs_rise  = ~cs_q[2]  &  cs_q[1];
    assign sck_fall =  sck_q[2] & ~sck_q[1];
    assign sck_rise = ~sck_q[2] &  sck_q[1];

    assign fall_inc  = (fall_cnt == '1) ? fall_cnt : fall_cnt + CW'(1);
    assign rise_inc  = (rise_cnt == '1) ? rise_cnt : rise_cnt + CW'(1);
    assign shreg_nxt = {shreg, sdi_q[1]};

    assign bus.sdo       = sdo_oe_q & sdo_sh[DATA_WIDTH-1];
    assign bus.sdo_oe    = sdo_oe_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.frame_err = frame_err_q;

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q  <= '0;
            sck_q <= '0;
            sdi_q <= '0;
        end else begin
            cs_q  <= {cs_q[1:0], bus.cs};
            sck_q <= {sck_q[1:0], sck_in};
            sdi_q <= {sdi_q[0], bus.sdi};
        end
    end

    // Frame decoder: address/data shifting, request strobes and sdo generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fall_cnt    <= '0;
            rise_cnt    <= '0;
            shreg       <= '0;
            addr_q      <= '0;
            is_read     <= 1'b0;
            overrun     <= 1'b0;
            loaded      <= 1'b0;
            lat_cnt     <= '0;
            sdo_sh      <= '0;
            sdo_oe_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
            if (state != S_IDLE && cs_rise) begin
                // cs rise takes priority over any sck edge detected in the same cycle.
                sdo_oe_q <= 1'b0;
                sdo_sh   <= '0;
                state    <= S_IDLE;
                if (state == S_DONE && !overrun) begin
                    if (!is_read) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= shreg[DATA_WIDTH-1:0];
                    end
                end else begin
                    frame_err_q <= 1'b1;
                end
            end else if (state == S_IDLE) begin
                if (cs_fall) begin
                    state    <= S_ADDR;
                    fall_cnt <= '0;
                    rise_cnt <= '0;
                    overrun  <= 1'b0;
                    is_read  <= 1'b0;
                    loaded   <= 1'b0;
                    lat_cnt  <= '0;
                end
            end else begin
                if (sck_rise) begin
                    rise_cnt <= rise_inc;
                    if (state == S_RDATA && loaded &&
                        rise_inc >= CNT_SHIFT0 && rise_inc <= CNT_FRAME) begin
                        sdo_sh <= {sdo_sh[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                // Count clk cycles after rd_req and capture the bank's answer exactly RD_LATENCY later.
                if (state == S_RDATA && !loaded) begin
                    if (lat_cnt == LAT) begin
                        sdo_sh   <= bus.rd_data;
                        sdo_oe_q <= 1'b1;
                        loaded   <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                if (sck_fall) begin
                    fall_cnt <= fall_inc;
                    case (state)
                        S_ADDR: begin
                            shreg <= shreg_nxt[SW-2:0];
                            if (fall_inc == CNT_ADDR) begin
                                addr_q <= shreg_nxt[ADDR_WIDTH-2:0];
                                if (shreg_nxt[ADDR_WIDTH-1]) begin
                                    is_read   <= 1'b1;
                                    rd_req_q  <= 1'b1;
                                    rd_addr_q <= shreg_nxt[ADDR_WIDTH-2:0];
                                    lat_cnt   <= '0;
                                    state     <= S_RDATA;
                                end else begin
                                    state <= S_WDATA;
                                end
                            end
                        end
                        S_WDATA: begin
                            shreg <= shreg_nxt[SW-2:0];
                            if (fall_inc == CNT_FRAME) begin
                                state <= S_DONE;
                            end
                        end
                        S_RDATA: begin
                            if (fall_inc == CNT_FRAME) begin
                                state <= S_DONE;
                            end
                        end
                        S_DONE: begin
                            overrun <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (target) for the team's 3/4-wire SPI initiator: same frame format and bit order. The initiator sends an ADDR_WIDTH-bit address, then a DATA_WIDTH-bit data phase, MSB first, with cs active low.
- Oversamples cs/sck/sdi in the local clk domain, decodes the frame and turns it into single-cycle register-file write or read requests.
- On reads it returns data on sdo with an output enable, which drives the sdio direction in 3-wire boards.
- Sits between FPGA pins and a local register bank, or emulates an SPI peripheral (ADC/DAC/PLL) in the bench.

Parameters:
ADDR_WIDTH, 16, address-phase bits; MSB is the R/W flag (1 = read), the low ADDR_WIDTH-1 bits are the register address
DATA_WIDTH, 8, data-phase bits
SCK_RISING_SHIFT, 1, 1: initiator shifts sdi on sck rise and samples on fall; 0: sck is inverted at input
RD_LATENCY, 1, clk cycles from rd_req to valid rd_data (1..4)

Ports:
clk  input  1  system clock; sck half period must be ≥ RD_LATENCY+6 clk
rst  input  1  asynchronous, active-high reset
cs  input  1  chip select, active low, asynchronous to clk
sck  input  1  serial clock, asynchronous to clk
sdi  input  1  serial data from initiator
sdo  output  1  serial read data to initiator
sdo_oe  output  1  high while the slave drives sdo (read data phase)
wr_en  output  1  one-cycle write strobe
wr_addr  output  ADDR_WIDTH-1  write register address
wr_data  output  DATA_WIDTH  write data
rd_req  output  1  one-cycle read request
rd_addr  output  ADDR_WIDTH-1  read register address
rd_data  input  DATA_WIDTH  read data, valid RD_LATENCY clk after rd_req
frame_err  output  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset: all outputs 0, synchronizers cleared, FSM in IDLE. Reset mid-frame discards the frame; after reset the slave waits for a new cs falling edge.
- Input path: 2-flop synchronizers on cs, sck, sdi; sck inverted first when SCK_RISING_SHIFT=0. Edge detect on the synchronized signals (3-clk input latency).
- Bit count: counts detected sck falling edges while cs is low. sdi is sampled into the shift register on each falling edge, so bit k is captured on fall k+1. Rising edges are counted separately for the sdo shift.
- FSM states:
  - IDLE: cs falling edge -> ADDR; clear counters.
  - ADDR: after fall ADDR_WIDTH, latch the address. R/W=0 -> WDATA. R/W=1 -> pulse rd_req with rd_addr next cycle, then RDATA.
  - WDATA: keep shifting sdi. Fall count reaching ADDR_WIDTH+DATA_WIDTH -> DONE.
  - RDATA:
    - RD_LATENCY clk after rd_req, load rd_data into the sdo shift register and assert sdo_oe; sdo then carries the data MSB.
    - Shift left on each sck rising edge numbered ADDR_WIDTH+2 .. ADDR_WIDTH+DATA_WIDTH, so data bit k is stable at fall ADDR_WIDTH+1+k.
    - Count reaching ADDR_WIDTH+DATA_WIDTH -> DONE.
  - DONE: extra falls set an overrun flag. cs rising edge -> IDLE.
- cs rising edge handling:
  - From DONE with a write frame and no overrun: wr_en=1 for exactly 1 clk on the cycle after detection, with wr_addr/wr_data stable from then until the next write.
  - From any other state, or with overrun: frame_err=1 for 1 clk and no write.
  - Read frames never produce wr_en.
- sdo_oe falls on the cycle the cs rise is detected. sdo=0 whenever sdo_oe=0.
- Simultaneous cs rise and sck edge in the same clk: the cs rise wins and the edge is ignored.
- Back-to-back frames with a cs high gap of ≥2 clk are handled independently.
- rd_req and wr_en are never high in the same cycle.

Test Plan:
- Write: ADDR_WIDTH=16, DATA_WIDTH=8, initiator half period 11 clk, addr 0x1234, data 0xA5 -> exactly one wr_en pulse ≤4 clk after cs rise, wr_addr=0x1234, wr_data=0xA5, no rd_req, sdo_oe stays 0.
- Read: addr 0x8042, bench returns rd_data=0x3C with RD_LATENCY=1 -> one rd_req with rd_addr=0x0042. Initiator captures 0x3C on its falling-edge samples, sdo_oe high only during the data phase, no wr_en.
- Abort: cs deasserted after 10 sck periods -> frame_err pulse, no wr_en or rd_req; the next full write frame (0x0001/0x5A) succeeds.
- Overlong: 26 sck periods with write addr 0x0010 -> frame_err, no wr_en.
- Reset mid-frame: assert rst at bit 12 of a write, release it, send write 0x0002/0xFF -> only that write appears, all outputs 0 during reset.
- Back-to-back: read 0x8003 then write 0x0003/0x77 with a 2-clk cs gap, and SCK_RISING_SHIFT=0 variant -> both frames decoded correctly.
